uart_byte_tx: RTL and testbench

UART transmitter paired with the design's UART receive path: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each as one start bit, 8 data bits and one stop bit on `uart_tx`. It sits beside the receiver in `top`, driving the Bluetooth module's RX line, and its frame format matches what the receiver expects. The default bit order is MSB first.

---
 rtl/uart_byte_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_byte_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//
// Byte-oriented UART transmitter. Bytes arrive over a valid/ready handshake,
// are queued in a small FIFO and are sent as 8N1 frames: one start bit (low),
// eight data bits, one stop bit (high). Frames queued behind each other are
// sent back-to-back with no idle time between the stop bit and the next start
// bit. The frame format matches the receive path that sits beside this block.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   MSB_FIRST     1: data bit 7 goes first on the line, 0: data bit 0 first
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; aborts any frame, empties the FIFO
//   in_data     byte to transmit
//   in_valid    in_data is valid; a byte is taken when in_valid && in_ready
//   in_ready    FIFO not full
//   uart_tx     serial line, idles high, registered
//   busy        registered; high from the pop that starts a frame until the
//               last stop bit ends with nothing left to send
//   fifo_count  bytes currently waiting in the FIFO (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int MSB_FIRST    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // A one-cycle bit still needs a (degenerate) counter of at least one bit.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("uart_byte_tx: CLKS_PER_BIT must be at least 1");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_byte_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Bit-order helpers: which bit of the shift register is on the line next,
    // and how the register moves so the following bit takes its place.
    // -------------------------------------------------------------------------
    function automatic logic out_bit(input logic [7:0] v);
        return (MSB_FIRST != 0) ? v[7] : v[0];
    endfunction

    function automatic logic [7:0] shift_next(input logic [7:0] v);
        return (MSB_FIRST != 0) ? {v[6:0], 1'b0} : {1'b0, v[7:1]};
    endfunction

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bit_last;
    logic             shift_now;

    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count != DEPTH_CNT);
    assign push       = in_valid && in_ready;
    assign bit_last   = (bit_cnt == CNT_LAST);

    // A byte leaves the FIFO either when the line is idle or at the very end
    // of a stop bit; the latter is what makes consecutive frames seamless.
    assign pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_last));

    // The register advances at the end of the start bit (exposing the first
    // data bit) and at the end of every data bit.
    assign shift_now = ((state == START) || (state == DATA)) && bit_last;

    // -------------------------------------------------------------------------
    // FIFO storage and shift register: data only, never reset. Their contents
    // are only consumed after the control logic has loaded them.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
        end else if (shift_now) begin
            shift_reg <= shift_next(shift_reg);
        end
    end

    // -------------------------------------------------------------------------
    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two; a simultaneous push and pop leaves the count alone.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Frame sequencer. uart_tx is registered and always set one edge ahead:
    // the value written on the edge that enters a state is the value that
    // state shows on the line for its CLKS_PER_BIT cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    if (pop) begin
                        state   <= START;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        uart_tx <= out_bit(shift_reg);
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            // shift_reg has already moved past the bit that
                            // just ended, so its output bit is the next one.
                            uart_tx <= out_bit(shift_reg);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            state   <= START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            uart_tx <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_tx
//
// Three transmitters with different timing and bit order run side by side,
// each with its own stimulus and its own reference model. The model keeps the
// queued bytes in a queue and derives the expected line level from the
// position inside the current frame (start, eight data bits, stop). Reset is
// shared so one mid-frame reset hits all three at once.
// -----------------------------------------------------------------------------
module tb_uart_byte_tx;

    localparam int N_CH  = 3;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    logic go_e;
    logic go_f;
    int   n_checks;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int ch, input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL ch%0d %s: got %0h expected %0h (t=%0t)", ch, tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        localparam int CPB = (g == 0) ? 1 : ((g == 1) ? 4 : 2);
        localparam int MSB = (g == 1) ? 0 : 1;

        logic [7:0] in_data;
        logic       in_valid;
        logic       in_ready;
        logic       uart_tx;
        logic       busy;
        logic [2:0] fifo_count;

        bit         rdy;
        bit         done;
        bit         stalled;
        int         pk;

        // Reference model state.
        logic [7:0] mq[$];
        bit         m_act;
        int         m_t;
        logic [7:0] m_cur;

        uart_byte_tx #(
            .CLKS_PER_BIT (CPB),
            .MSB_FIRST    (MSB),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_data    (in_data),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .uart_tx    (uart_tx),
            .busy       (busy),
            .fifo_count (fifo_count)
        );

        // Line level at frame position m_t: bit period 0 is the start bit,
        // periods 1..8 are data, period 9 is the stop bit.
        function automatic logic exp_line();
            int k;
            if (!m_act) return 1'b1;
            if (m_t < CPB) return 1'b0;
            if (m_t >= 9 * CPB) return 1'b1;
            k = m_t / CPB - 1;
            return (MSB != 0) ? m_cur[3'(7 - k)] : m_cur[3'(k)];
        endfunction

        initial begin : model
            int qn;
            m_act = 1'b0;
            m_t   = 0;
            m_cur = '0;
            wait (reset === 1'b1);
            forever begin
                @(posedge clk);
                if (reset) begin
                    mq.delete();
                    m_act = 1'b0;
                    m_t   = 0;
                end else begin
                    qn = mq.size();
                    if (m_act && m_t < 10 * CPB - 1) begin
                        m_t++;
                    end else if (qn > 0) begin
                        m_cur = mq.pop_front();
                        m_act = 1'b1;
                        m_t   = 0;
                    end else begin
                        m_act = 1'b0;
                    end
                    if (in_valid && qn < DEPTH) mq.push_back(in_data);
                end
                @(negedge clk);
                chk(g, "line",  32'(uart_tx),    32'(exp_line()));
                chk(g, "busy",  32'(busy),       32'(m_act));
                chk(g, "count", 32'(fifo_count), 32'(mq.size()));
                chk(g, "ready", 32'(in_ready),   32'(mq.size() != DEPTH));
            end
        end

        // Reset acts immediately, without waiting for a clock edge.
        initial begin : rst_watch
            forever begin
                @(posedge reset);
                #1;
                chk(g, "reset line",  32'(uart_tx),    32'(1));
                chk(g, "reset busy",  32'(busy),       32'(0));
                chk(g, "reset count", 32'(fifo_count), 32'(0));
                chk(g, "reset ready", 32'(in_ready),   32'(1));
            end
        end

        // Present a byte at a falling edge and hold it until it is taken.
        task automatic push(input logic [7:0] b);
            int n;
            n        = 0;
            in_data  = b;
            in_valid = 1'b1;
            while (in_ready !== 1'b1 && n < 2000) begin
                stalled = 1'b1;
                @(negedge clk);
                n++;
            end
            if (n >= 2000) chk(g, "push wait", 32'(in_ready), 32'(1));
            @(negedge clk);
            in_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            if (int'(fifo_count) > pk) pk = int'(fifo_count);
            while (!(busy === 1'b0 && fifo_count === 3'd0) && n < 3000) begin
                @(negedge clk);
                if (int'(fifo_count) > pk) pk = int'(fifo_count);
                n++;
            end
            if (n >= 3000) chk(g, "idle wait", 32'(busy), 32'(0));
        endtask

        initial begin : stim
            logic [9:0] pat;
            int         busy_cyc;
            in_valid = 1'b0;
            in_data  = '0;
            rdy      = 1'b0;
            done     = 1'b0;
            stalled  = 1'b0;
            pk       = 0;
            wait (reset === 1'b1);
            wait (reset === 1'b0);
            @(negedge clk);

            // Single frame, checked against the literal line sequence.
            pat = (g == 1) ? 10'b0100000001 : 10'b0101001011;
            push((g == 1) ? 8'h01 : 8'hA5);
            busy_cyc = 0;
            for (int i = 0; i < 10 * CPB + 2; i++) begin
                @(negedge clk);
                chk(g, "frame bit", 32'(uart_tx),
                    32'((i < 10 * CPB) ? pat[9 - i / CPB] : 1'b1));
                busy_cyc += int'(busy);
            end
            chk(g, "busy cycles", 32'(busy_cyc), 32'(10 * CPB));

            // Three bytes on consecutive cycles.
            pk = 0;
            push(8'h00);
            if (int'(fifo_count) > pk) pk = int'(fifo_count);
            push(8'hFF);
            if (int'(fifo_count) > pk) pk = int'(fifo_count);
            push(8'h3C);
            wait_idle();
            chk(g, "peak count", 32'(pk), 32'(2));

            // Six bytes held against a four-entry FIFO.
            stalled = 1'b0;
            for (int i = 0; i < 6; i++) push(8'h10 + 8'(i * 17));
            wait_idle();
            chk(g, "stalled when full", 32'(stalled), 32'(1));

            // Random bytes with random gaps.
            for (int i = 0; i < 30; i++) begin
                push(8'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(0, 12 * CPB)) @(negedge clk);
                end
            end
            wait_idle();

            // Two bytes queued; reset lands during the first one's data bits.
            rdy = 1'b1;
            wait (go_e);
            push(8'h55);
            push(8'hAA);
            wait (go_f);
            @(negedge clk);
            push(8'h81);
            wait_idle();

            // Push coinciding with a pop, once at frame start and once at the
            // end of a stop bit.
            push(8'hC3);
            push(8'h5A);
            chk(g, "count push+pop start", 32'(fifo_count), 32'(1));
            repeat (10 * CPB - 1) @(negedge clk);
            push(8'h96);
            chk(g, "count push+pop stop", 32'(fifo_count), 32'(1));
            wait_idle();
            done = 1'b1;
        end
    end

    initial begin : main
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b0;
        go_e     = 1'b0;
        go_f     = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        wait (g_ch[0].rdy && g_ch[1].rdy && g_ch[2].rdy);
        @(negedge clk);
        go_e = 1'b1;
        // 0x55 is taken at the first edge; five edges later every channel is
        // inside the data bits of that frame.
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        go_f = 1'b1;

        wait (g_ch[0].done && g_ch[1].done && g_ch[2].done);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish in time (%0d of %0d checks passed)",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
